key_word_loader: RTL and testbench
==================================

Name: key_word_loader

Overview:
- Upstream feeder for the key-consuming stage (128-bit key in, 64-bit `load` out, registered).
- Accepts the key as four 32-bit words over a valid/ready stream and assembles them in a shadow register.
- Publishes the full 128-bit key atomically, with a valid flag, so the downstream stage never samples a partially written key.
- Reports framing errors and stalled transfers, and counts completed keys.

Parameters:
- MSW_FIRST, 1: 1 = first accepted word lands in key[127:96], last in key[31:0]. 0 = first word lands in key[31:0], last in key[127:96].
- TIMEOUT_CYCLES, 16'd1023: maximum idle cycles between words in COLLECT before the transfer aborts. 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  word offered
- in_ready  output  1  block can accept a word this cycle
- in_data  input  32  key word
- in_last  input  1  marks the 4th (final) word of a key
- clear  input  1  synchronous pulse: zeroise key, drop valid, clear error, abort transfer
- key  output  128  assembled key, held stable until the next complete key or clear
- key_valid  output  1  key holds a complete, error-free key
- err  output  1  sticky framing/timeout error
- key_count  output  8  number of completed keys, saturating at 255

Behaviour:
- Reset values: key=0, key_valid=0, err=0, key_count=0, state=IDLE, word index=0, shadow=0, timeout counter=0. in_ready=1 once out of reset.
- Handshake: a word is accepted on a rising edge where in_valid && in_ready.
  - in_ready = !clear in every state; no backpressure otherwise.
  - in_data and in_last are sampled only on acceptance.
- States:
  - IDLE: no transfer in progress. An accepted word is written to shadow slot 0, index←1, and the state moves to COLLECT.
  - COLLECT: each accepted word is written to shadow slot[index], and index increments.
  - READY: a complete key is published. An accepted word starts a new key: slot 0 is written, key_valid←0 on the same edge, the state moves to COLLECT, and the key output keeps its old value (flagged invalid).
- Slot mapping:
  - MSW_FIRST=1: slot i → key[127-32i -: 32].
  - MSW_FIRST=0: slot i → key[32i +: 32].
- Completion: when the 4th word (index 3) is accepted with in_last=1:
  - key←{shadow with 4th word} and key_valid←1, both visible the cycle after acceptance (1-cycle latency).
  - key_count increments unless already at 255.
  - The state moves to READY and index←0.
- Framing error: in_last=1 on a word with index<3, or in_last=0 on the word with index 3.
  - The word is discarded and err←1 (sticky).
  - Shadow←0, index←0, state→IDLE.
  - key, key_valid and key_count are unchanged from before the transfer; key_valid was already 0 if the transfer started from READY.
- Timeout: in COLLECT, the timeout counter increments on every cycle with no accepted word and resets to 0 on every accept.
  - When it reaches TIMEOUT_CYCLES (nonzero), the transfer aborts exactly as a framing error does.
  - The counter is held at 0 outside COLLECT.
- clear (highest priority):
  - On the clock edge, key←0, key_valid←0, err←0, shadow←0, index←0, state→IDLE.
  - key_count is not cleared; only rst clears it.
  - Since in_ready=0 while clear=1, no word is accepted in that cycle.
- Reset mid-transfer: all state returns immediately (asynchronously) to the reset values, and the partial key is lost.
- Shadow register contents never appear on key until a transfer completes.
- No combinational path from in_data to key.

Test Plan:
- MSW_FIRST=1; words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF (last on 4th), one word per cycle -> key=0x00112233_44556677_8899AABB_CCDDEEFF and key_valid=1 one cycle after the 4th accept; key_count=1.
- Same words with MSW_FIRST=0 and gaps of 3 idle cycles between words -> key=0xCCDDEEFF_8899AABB_44556677_00112233 and key_valid=1; key stays 0 and key_valid=0 throughout collection.
- Key A complete, then 2 words of key B -> key_valid drops on the first B accept while key still shows A; after the 4th B word, key=B, key_valid=1, key_count=2.
- in_last=1 on the 2nd word -> err=1, state IDLE, key_valid=0; next 4 valid words complete normally with err still 1; clear pulse -> err=0, key=0, key_valid=0, key_count unchanged.
- TIMEOUT_CYCLES=8, 1 word then idle -> err=1 exactly 8 cycles after the accept. With clear asserted together with in_valid, in_ready=0 and the word is not counted. Asserting rst mid-transfer -> all outputs 0 immediately.
- 256 complete keys -> key_count saturates at 255.

Source files
------------

// File: rtl/key_word_loader_if.sv
//------------------------------------------------------------------------------
// Module      : key_word_loader_if
// Description : Word stream, control and published-key signals of the loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface key_word_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         clear;
  logic [127:0] key;
  logic         key_valid;
  logic         err;
  logic [7:0]   key_count;

  modport master (
    output in_valid, in_data, in_last, clear,
    input  in_ready, key, key_valid, err, key_count
  );

  modport slave (
    input  in_valid, in_data, in_last, clear,
    output in_ready, key, key_valid, err, key_count
  );
endinterface

`default_nettype wire

// File: rtl/key_word_loader.sv
//------------------------------------------------------------------------------
// Module      : key_word_loader
// Description : Assembles four 32-bit stream words into a shadow register and
//               publishes the complete 128-bit key atomically with a valid flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_word_loader #(
  parameter bit          MSW_FIRST      = 1'b1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023
) (
  input  wire logic         clk,
  input  wire logic         rst,
  key_word_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  localparam logic [1:0] c_LAST_IDX = 2'd3;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [127:0]  r_shadow;
  logic [127:0]  r_key;
  logic          r_key_valid;
  logic          r_err;
  logic [7:0]    r_count;
  logic [15:0]   r_timer;

  state_t        w_state;
  logic [1:0]    w_idx;
  logic [127:0]  w_shadow;
  logic [127:0]  w_key;
  logic          w_key_valid;
  logic          w_err;
  logic [7:0]    w_count;
  logic [15:0]   w_timer;

  logic          w_ready;
  logic          w_accept;
  logic          w_is_final;
  logic          w_frame_err;
  logic          w_timeout;
  logic [127:0]  w_shadow_wr;

  // Bit position of the low end of a slot inside the 128-bit key.
  function automatic logic [6:0] slot_lsb(input logic [1:0] slot);
    logic [6:0] w_off;
    w_off = {slot, 5'd0};
    return MSW_FIRST ? (7'd96 - w_off) : w_off;
  endfunction

  assign w_ready     = !bus.clear;
  assign w_accept    = bus.in_valid && w_ready;
  assign w_is_final  = (r_idx == c_LAST_IDX);
  assign w_frame_err = w_accept && (bus.in_last != w_is_final);
  assign w_timeout   = (TIMEOUT_CYCLES != 16'd0) && (r_state == ST_COLLECT) &&
                       !w_accept && (r_timer == (TIMEOUT_CYCLES - 16'd1));

  always_comb begin
    w_shadow_wr = r_shadow;
    w_shadow_wr[slot_lsb(r_idx) +: 32] = bus.in_data;
  end

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_shadow    = r_shadow;
    w_key       = r_key;
    w_key_valid = r_key_valid;
    w_err       = r_err;
    w_count     = r_count;
    w_timer     = 16'd0;

    if (bus.clear) begin
      w_key       = '0;
      w_key_valid = 1'b0;
      w_err       = 1'b0;
      w_shadow    = '0;
      w_idx       = 2'd0;
      w_state     = ST_IDLE;
    end else if (w_accept) begin
      // Any accepted word invalidates the published key; old value stays put.
      w_key_valid = 1'b0;
      if (w_frame_err) begin
        w_err    = 1'b1;
        w_shadow = '0;
        w_idx    = 2'd0;
        w_state  = ST_IDLE;
      end else if (w_is_final) begin
        w_key       = w_shadow_wr;
        w_key_valid = 1'b1;
        w_count     = (r_count == 8'hFF) ? r_count : (r_count + 8'd1);
        w_shadow    = '0;
        w_idx       = 2'd0;
        w_state     = ST_READY;
      end else begin
        w_shadow = w_shadow_wr;
        w_idx    = r_idx + 2'd1;
        w_state  = ST_COLLECT;
      end
    end else if (w_timeout) begin
      w_err    = 1'b1;
      w_shadow = '0;
      w_idx    = 2'd0;
      w_state  = ST_IDLE;
    end else if (r_state == ST_COLLECT) begin
      w_timer = r_timer + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_shadow    <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= 8'd0;
      r_timer     <= 16'd0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_shadow    <= w_shadow;
      r_key       <= w_key;
      r_key_valid <= w_key_valid;
      r_err       <= w_err;
      r_count     <= w_count;
      r_timer     <= w_timer;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.key       = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.err       = r_err;
  assign bus.key_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_key_word_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_key_word_loader
// Description : Drives two loaders (MSW-first with timeout 8, LSW-first with
//               timeout disabled) and checks them against a word-queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_word_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_valid = 1'b0;
  logic [31:0] tb_data = '0;
  logic        tb_last = 1'b0;
  logic        tb_clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_word_loader_if ifa ();
  key_word_loader_if ifb ();

  assign ifa.in_valid = tb_valid;
  assign ifa.in_data  = tb_data;
  assign ifa.in_last  = tb_last;
  assign ifa.clear    = tb_clear;
  assign ifb.in_valid = tb_valid;
  assign ifb.in_data  = tb_data;
  assign ifb.in_last  = tb_last;
  assign ifb.clear    = tb_clear;

  key_word_loader #(.MSW_FIRST(1'b1), .TIMEOUT_CYCLES(16'd8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  key_word_loader #(.MSW_FIRST(1'b0), .TIMEOUT_CYCLES(16'd0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  // Reference model: a list of words received so far per loader.
  logic [31:0]  mq    [2][4];
  int           mn    [2];
  logic [127:0] mkey  [2];
  bit           mval  [2];
  bit           merr  [2];
  int           mcnt  [2];
  int           midle [2];

  function automatic int to_of(input int m);
    return (m == 0) ? 8 : 0;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mn[m] = 0; mkey[m] = '0; mval[m] = 0; merr[m] = 0; mcnt[m] = 0; midle[m] = 0;
      end else if (tb_clear) begin
        mn[m] = 0; mkey[m] = '0; mval[m] = 0; merr[m] = 0; midle[m] = 0;
      end else if (tb_valid) begin
        mval[m]  = 0;
        midle[m] = 0;
        if (tb_last != (mn[m] == 3)) begin
          merr[m] = 1;
          mn[m]   = 0;
        end else begin
          mq[m][mn[m]] = tb_data;
          mn[m]++;
          if (mn[m] == 4) begin
            if (m == 0) mkey[m] = {mq[m][0], mq[m][1], mq[m][2], mq[m][3]};
            else        mkey[m] = {mq[m][3], mq[m][2], mq[m][1], mq[m][0]};
            mval[m] = 1;
            if (mcnt[m] < 255) mcnt[m]++;
            mn[m] = 0;
          end
        end
      end else if (mn[m] > 0 && to_of(m) != 0) begin
        midle[m]++;
        if (midle[m] == to_of(m)) begin
          merr[m] = 1; mn[m] = 0; midle[m] = 0;
        end
      end
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 50)
        $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("A.key",       ifa.key,            mkey[0]);
      chk("A.key_valid", 128'(ifa.key_valid), 128'(mval[0]));
      chk("A.err",       128'(ifa.err),      128'(merr[0]));
      chk("A.key_count", 128'(ifa.key_count), 128'(mcnt[0]));
      chk("A.in_ready",  128'(ifa.in_ready), 128'(!tb_clear));
      chk("B.key",       ifb.key,            mkey[1]);
      chk("B.key_valid", 128'(ifb.key_valid), 128'(mval[1]));
      chk("B.err",       128'(ifb.err),      128'(merr[1]));
      chk("B.key_count", 128'(ifb.key_count), 128'(mcnt[1]));
      chk("B.in_ready",  128'(ifb.in_ready), 128'(!tb_clear));
    end
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic put(input logic [31:0] d, input logic l);
    tb_valid = 1'b1; tb_data = d; tb_last = l;
    cyc();
    tb_valid = 1'b0; tb_last = 1'b0;
  endtask

  task automatic pulse_clear();
    tb_clear = 1'b1;
    cyc();
    tb_clear = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w0, w1, w2, w3, input int gap);
    put(w0, 1'b0); idle(gap);
    put(w1, 1'b0); idle(gap);
    put(w2, 1'b0); idle(gap);
    put(w3, 1'b1);
  endtask

  localparam logic [127:0] c_KA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] c_KB = 128'hCCDDEEFF_8899AABB_44556677_00112233;

  initial begin
    logic [31:0] x0, x1, x2, x3;

    idle(3);
    chk("rst.A.key",       ifa.key, 128'd0);
    chk("rst.A.key_valid", 128'(ifa.key_valid), 128'd0);
    chk("rst.A.err",       128'(ifa.err), 128'd0);
    chk("rst.A.key_count", 128'(ifa.key_count), 128'd0);
    rst = 1'b0;
    idle(2);

    // Back-to-back words.
    send4(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 0);
    chk("t1.A.key",       ifa.key, c_KA);
    chk("t1.A.key_valid", 128'(ifa.key_valid), 128'd1);
    chk("t1.A.key_count", 128'(ifa.key_count), 128'd1);
    chk("t1.B.key",       ifb.key, c_KB);

    // Gapped words after a clear.
    pulse_clear();
    chk("t2.A.key_cleared", ifa.key, 128'd0);
    chk("t2.A.count_kept",  128'(ifa.key_count), 128'd1);
    send4(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 3);
    chk("t2.B.key",       ifb.key, c_KB);
    chk("t2.B.key_valid", 128'(ifb.key_valid), 128'd1);
    chk("t2.A.key",       ifa.key, c_KA);

    // New key overwrites a published one.
    x0 = $urandom; x1 = $urandom; x2 = $urandom; x3 = $urandom;
    put(x0, 1'b0);
    chk("t3.A.valid_drop", 128'(ifa.key_valid), 128'd0);
    chk("t3.A.key_held",   ifa.key, c_KA);
    put(x1, 1'b0); put(x2, 1'b0); put(x3, 1'b1);
    chk("t3.A.key",   ifa.key, {x0, x1, x2, x3});
    chk("t3.B.key",   ifb.key, {x3, x2, x1, x0});
    chk("t3.A.count", 128'(ifa.key_count), 128'd3);

    // Early last is a framing error; err is sticky until clear.
    put(32'h1111_1111, 1'b0);
    put(32'h2222_2222, 1'b1);
    chk("t4.A.err",   128'(ifa.err), 128'd1);
    chk("t4.A.valid", 128'(ifa.key_valid), 128'd0);
    send4(32'hA, 32'hB, 32'hC, 32'hD, 0);
    chk("t4.A.err_sticky", 128'(ifa.err), 128'd1);
    chk("t4.A.valid2",     128'(ifa.key_valid), 128'd1);
    pulse_clear();
    chk("t4.A.err_clr",   128'(ifa.err), 128'd0);
    chk("t4.A.key_clr",   ifa.key, 128'd0);
    chk("t4.A.count",     128'(ifa.key_count), 128'd4);

    // Timeout on A fires on the 8th idle cycle; B has it disabled.
    put(32'h5555_5555, 1'b0);
    idle(7);
    chk("t5.A.err_early", 128'(ifa.err), 128'd0);
    idle(1);
    chk("t5.A.err_to",    128'(ifa.err), 128'd1);
    chk("t5.B.err_none",  128'(ifb.err), 128'd0);

    // A word offered together with clear is not taken.
    tb_clear = 1'b1; tb_valid = 1'b1; tb_data = 32'hDEAD_BEEF; tb_last = 1'b0;
    #1;
    chk("t5.A.ready_clr", 128'(ifa.in_ready), 128'd0);
    cyc();
    tb_clear = 1'b0; tb_valid = 1'b0;
    send4(32'h1, 32'h2, 32'h3, 32'h4, 0);
    chk("t5.A.count", 128'(ifa.key_count), 128'd5);
    chk("t5.B.key",   ifb.key, 128'h00000004_00000003_00000002_00000001);

    // Asynchronous reset in the middle of a transfer.
    put(32'h7, 1'b0); put(32'h8, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("t5.rst.A.key",   ifa.key, 128'd0);
    chk("t5.rst.A.valid", 128'(ifa.key_valid), 128'd0);
    chk("t5.rst.A.count", 128'(ifa.key_count), 128'd0);
    chk("t5.rst.B.key",   ifb.key, 128'd0);
    cyc();
    rst = 1'b0;
    idle(1);

    // Randomised traffic, mostly well framed.
    repeat (600) begin
      tb_valid = ($urandom % 100) < 70;
      tb_data  = $urandom;
      tb_last  = (mn[0] == 3) ^ (($urandom % 20) == 0);
      tb_clear = ($urandom % 60) == 0;
      cyc();
      if (($urandom % 30) == 0) begin
        tb_valid = 1'b0; tb_clear = 1'b0;
        idle($urandom_range(5, 12));
      end
    end
    tb_valid = 1'b0;
    pulse_clear();

    // Counter saturation.
    repeat (256) send4($urandom, $urandom, $urandom, $urandom, 0);
    chk("t6.A.count_sat", 128'(ifa.key_count), 128'd255);
    chk("t6.B.count_sat", 128'(ifb.key_count), 128'd255);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
